// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR sequencer and the datapath it drives:
//   - instruction field bit positions (64-bit instruction word)
//   - opcode constants
//   - ALU op select constants (shared with the datapath ALUs)
//   - sequencer state encoding
//   - packed control-strobe struct, laid out in instruction bit order so a
//     straight cast of instr[CTRL_HI:CTRL_LO] yields the decoded strobes
// ---------------------------------------------------------------------------
package fir_pkg;

    // Instruction field positions
    localparam int OPC_HI  = 63;
    localparam int OPC_LO  = 60;
    localparam int CTRL_HI = 59;
    localparam int CTRL_LO = 46;
    localparam int ADDR_HI = 31;
    localparam int ADDR_LO = 16;
    localparam int CNT_HI  = 15;
    localparam int CNT_LO  = 0;

    // Opcodes; anything not listed decodes as NOP
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_EXEC = 4'd1;
    localparam logic [3:0] OP_LOOP = 4'd2;
    localparam logic [3:0] OP_JUMP = 4'd3;
    localparam logic [3:0] OP_HALT = 4'd4;

    // ALU op selects understood by the datapath ALUs
    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_MAC  = 3'd3;
    localparam logic [2:0] ALU_MUL  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;
    localparam logic [2:0] ALU_CLR  = 3'd6;
    localparam logic [2:0] ALU_SHR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // First member is the MSB: matches instr[59:46] bit for bit
    typedef struct packed {
        logic       dm1_we;
        logic       dm2_we;
        logic       rf1_we;
        logic       rf2_we;
        logic       dag1_re;
        logic       dag2_re;
        logic       dag1_we;
        logic       dag2_we;
        logic [2:0] alu1_ctrl;
        logic [2:0] alu2_ctrl;
    } ctrl_t;

endpackage

// File: rtl/fir_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_sequencer_if
// Bus between the sequencer and the rest of the FIR engine.
//   master (sequencer): in  start, instr
//                       out pc, memory/regfile/DAG strobes, ALU selects,
//                           loop_we, busy, done, err, loop_cnt
//   slave  (datapath / imem / host): the mirror image
// ---------------------------------------------------------------------------
interface fir_sequencer_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 64
);
    logic               start;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               dm1_we, dm2_we;
    logic               rf1_we, rf2_we;
    logic               dag1_re, dag2_re, dag1_we, dag2_we;
    logic [2:0]         alu1_ctrl, alu2_ctrl;
    logic               loop_we;
    logic               busy, done, err;
    logic [15:0]        loop_cnt;

    modport master (
        input  start, instr,
        output pc, dm1_we, dm2_we, rf1_we, rf2_we,
               dag1_re, dag2_re, dag1_we, dag2_we,
               alu1_ctrl, alu2_ctrl, loop_we, busy, done, err, loop_cnt
    );

    modport slave (
        output start, instr,
        input  pc, dm1_we, dm2_we, rf1_we, rf2_we,
               dag1_re, dag2_re, dag1_we, dag2_we,
               alu1_ctrl, alu2_ctrl, loop_we, busy, done, err, loop_cnt
    );
endinterface

// File: rtl/fir_loop_ctrl.sv
// ---------------------------------------------------------------------------
// fir_loop_ctrl
// Single-level zero-overhead loop state.
//   clk, reset   : clock, synchronous active-high reset
//   clr          : drop any active loop (jump / restart)
//   load         : arm a loop with start_pc / end_pc / count
//   step         : the loop_end instruction is issuing this cycle
//   pc           : current fetch address
//   active       : a loop is armed
//   at_end       : active and pc == loop_end
//   back         : at_end and more iterations remain -> branch to target
//   target       : loop_start
//   cnt          : remaining iterations (0 when idle)
// ---------------------------------------------------------------------------
module fir_loop_ctrl #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            load,
    input  logic            step,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] start_pc,
    input  logic [PC_W-1:0] end_pc,
    input  logic [15:0]     load_cnt,
    output logic            active,
    output logic            at_end,
    output logic            back,
    output logic [PC_W-1:0] target,
    output logic [15:0]     cnt
);
    logic [PC_W-1:0] loop_start;
    logic [PC_W-1:0] loop_end;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            active     <= 1'b0;
            cnt        <= '0;
            loop_start <= '0;
            loop_end   <= '0;
        end else if (load) begin
            active     <= 1'b1;
            cnt        <= load_cnt;
            loop_start <= start_pc;
            loop_end   <= end_pc;
        end else if (step) begin
            if (cnt > 16'd1) begin
                cnt <= cnt - 16'd1;
            end else begin
                // last pass through the body falls out of the loop
                active <= 1'b0;
                cnt    <= '0;
            end
        end
    end

    assign at_end = active && (pc == loop_end);
    assign back   = at_end && (cnt > 16'd1);
    assign target = loop_start;
endmodule

// File: rtl/fir_sequencer.sv
// ---------------------------------------------------------------------------
// fir_sequencer
// Program sequencer / instruction decoder for the FIR datapath.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fir_sequencer_if master port
//                start in, instr in (async-read imem at bus.pc),
//                pc out, registered control strobes out, loop_we pulse,
//                busy (RUN), done (HALT), err (sticky nested-loop),
//                loop_cnt (remaining loop iterations)
// The instruction at pc is decoded combinationally while in RUN; the next pc
// is chosen in the same cycle (no delay slot) and all strobes are registered,
// so they appear the cycle after their instruction is fetched.
// ---------------------------------------------------------------------------
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fir_sequencer_if.master    bus
);
    state_e              state;
    logic [PC_W-1:0]     pc, pc_nxt, pc_inc;
    ctrl_t               ctrl_q;
    logic                loop_we_q, busy_q, done_q, err_q;

    logic [INSTR_W-1:0]  instr;
    logic [3:0]          op;
    ctrl_t               dec_ctrl;
    logic [15:0]         f_addr, f_cnt;
    logic                unused_bits;

    logic                run, restart;
    logic                lp_load, lp_clr, lp_step, nested, loop_pulse;
    logic                lp_active, lp_at_end, lp_back;
    logic [PC_W-1:0]     lp_target;
    logic [15:0]         lp_cnt;

    assign instr       = bus.instr;
    assign op          = instr[OPC_HI:OPC_LO];
    assign dec_ctrl    = ctrl_t'(instr[CTRL_HI:CTRL_LO]);
    assign f_addr      = instr[ADDR_HI:ADDR_LO];
    assign f_cnt       = instr[CNT_HI:CNT_LO];
    assign unused_bits = ^instr[CTRL_LO-1:ADDR_HI+1];

    assign run     = (state == ST_RUN);
    // start is only honoured outside RUN; it also wipes any stale loop
    assign restart = bus.start && !run;
    assign pc_inc  = pc + PC_W'(1);

    // Next-pc selection and loop sequencing, in priority order
    always_comb begin
        pc_nxt     = pc_inc;
        lp_load    = 1'b0;
        lp_step    = 1'b0;
        nested     = 1'b0;
        loop_pulse = 1'b0;
        if (run) begin
            case (op)
                OP_HALT: pc_nxt = pc;
                OP_JUMP: pc_nxt = PC_W'(f_addr);
                OP_LOOP: begin
                    if (lp_active) begin
                        // nested LOOP: flag it, otherwise behave as NOP so the
                        // outer loop still sees its loop_end
                        nested = 1'b1;
                        if (lp_at_end) begin
                            lp_step = 1'b1;
                            if (lp_back) pc_nxt = lp_target;
                        end
                    end else if (f_cnt == 16'd0) begin
                        pc_nxt     = PC_W'(f_addr) + PC_W'(1);
                        loop_pulse = 1'b1;
                    end else begin
                        lp_load    = 1'b1;
                        loop_pulse = 1'b1;
                    end
                end
                default: begin
                    if (lp_at_end) begin
                        lp_step = 1'b1;
                        if (lp_back) pc_nxt = lp_target;
                    end
                end
            endcase
        end
    end

    assign lp_clr = (run && op == OP_JUMP) || restart;

    fir_loop_ctrl #(.PC_W(PC_W)) u_loop (
        .clk      (clk),
        .reset    (reset),
        .clr      (lp_clr),
        .load     (lp_load),
        .step     (lp_step),
        .pc       (pc),
        .start_pc (pc_inc),
        .end_pc   (PC_W'(f_addr)),
        .load_cnt (f_cnt),
        .active   (lp_active),
        .at_end   (lp_at_end),
        .back     (lp_back),
        .target   (lp_target),
        .cnt      (lp_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ctrl_q    <= '0;
            loop_we_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ctrl_q    <= '0;
            loop_we_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        pc     <= RESET_PC;
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pc        <= pc_nxt;
                    loop_we_q <= loop_pulse;
                    if (op == OP_EXEC) ctrl_q <= dec_ctrl;
                    if (nested) err_q <= 1'b1;
                    if (op == OP_HALT) begin
                        state  <= ST_HALT;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        pc     <= RESET_PC;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc;
    assign bus.dm1_we    = ctrl_q.dm1_we;
    assign bus.dm2_we    = ctrl_q.dm2_we;
    assign bus.rf1_we    = ctrl_q.rf1_we;
    assign bus.rf2_we    = ctrl_q.rf2_we;
    assign bus.dag1_re   = ctrl_q.dag1_re;
    assign bus.dag2_re   = ctrl_q.dag2_re;
    assign bus.dag1_we   = ctrl_q.dag1_we;
    assign bus.dag2_we   = ctrl_q.dag2_we;
    assign bus.alu1_ctrl = ctrl_q.alu1_ctrl;
    assign bus.alu2_ctrl = ctrl_q.alu2_ctrl;
    assign bus.loop_we   = loop_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.loop_cnt  = lp_cnt;
endmodule

// File: tb/tb_fir_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_sequencer
// Directed bench: small programs in a behavioural async-read imem, expected
// pc / strobe / loop values written out cycle by cycle.
// ---------------------------------------------------------------------------
module tb_fir_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    fir_sequencer_if #(.PC_W(16), .INSTR_W(64)) bus();

    fir_sequencer #(.PC_W(16), .INSTR_W(64), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] imem [0:255];
    assign bus.instr = imem[bus.pc[7:0]];

    // strobes in instruction-field order
    logic [13:0] strb;
    assign strb = {bus.dm1_we, bus.dm2_we, bus.rf1_we, bus.rf2_we,
                   bus.dag1_re, bus.dag2_re, bus.dag1_we, bus.dag2_we,
                   bus.alu1_ctrl, bus.alu2_ctrl};

    localparam logic [3:0]  NOP = 4'd0, EXEC = 4'd1, LOOP = 4'd2, JUMP = 4'd3, HALT = 4'd4;
    localparam logic [13:0] C_DM2  = 14'h1000;
    localparam logic [13:0] C_RF1  = 14'h0800;
    localparam logic [13:0] C_RF2  = 14'h0400;
    localparam logic [13:0] C_DAG1 = 14'h0200;

    int tests = 0;
    int fails = 0;
    int rf1_n, rf2_n, lwe_n;

    function automatic logic [63:0] ins(input logic [3:0] op, input logic [13:0] ctl,
                                        input logic [15:0] addr, input logic [15:0] cnt);
        return {op, ctl, 14'd0, addr, cnt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) imem[i] = 64'd0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic step(input string tag, input logic [15:0] epc, input logic [15:0] ecnt,
                        input logic [13:0] es, input logic elwe);
        tick();
        chk({tag, ".pc"}, 32'(bus.pc), 32'(epc));
        chk({tag, ".cnt"}, 32'(bus.loop_cnt), 32'(ecnt));
        chk({tag, ".strb"}, 32'(strb), 32'(es));
        chk({tag, ".lwe"}, 32'(bus.loop_we), 32'(elwe));
        rf1_n += int'(bus.rf1_we);
        rf2_n += int'(bus.rf2_we);
        lwe_n += int'(bus.loop_we);
    endtask

    initial begin
        bus.start = 1'b0;
        clr_mem();

        // ---- reset state ----
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.pc", 32'(bus.pc), 32'h0);
        chk("rst.busy", 32'(bus.busy), 32'h0);
        chk("rst.done", 32'(bus.done), 32'h0);
        chk("rst.err", 32'(bus.err), 32'h0);
        chk("rst.cnt", 32'(bus.loop_cnt), 32'h0);
        chk("rst.strb", 32'(strb), 32'h0);
        chk("rst.lwe", 32'(bus.loop_we), 32'h0);
        // start ignored until asserted: still idle after another edge
        tick();
        chk("idle.busy", 32'(bus.busy), 32'h0);

        // ---- straight-line ----
        imem[0] = ins(EXEC, 14'h2018, 16'h0, 16'h0);   // dm1_we, alu1=3
        imem[1] = ins(EXEC, 14'h0005, 16'h0, 16'h0);   // alu2=5
        imem[2] = ins(HALT, 14'h0, 16'h0, 16'h0);
        pulse_start();
        chk("sl.busy", 32'(bus.busy), 32'h1);
        chk("sl.pc0", 32'(bus.pc), 32'h0);
        chk("sl.strb0", 32'(strb), 32'h0);
        step("sl1", 16'd1, 16'd0, 14'h2018, 1'b0);
        step("sl2", 16'd2, 16'd0, 14'h0005, 1'b0);
        step("sl3", 16'd2, 16'd0, 14'h0000, 1'b0);
        chk("sl.done", 32'(bus.done), 32'h1);
        chk("sl.busy_lo", 32'(bus.busy), 32'h0);
        step("sl4", 16'd2, 16'd0, 14'h0000, 1'b0);
        chk("sl.done_hold", 32'(bus.done), 32'h1);

        // ---- jump ----
        clr_mem();
        imem[0]     = ins(JUMP, 14'h3fff, 16'h0010, 16'h0);  // ctl bits must not leak
        imem[8'h10] = ins(HALT, 14'h0, 16'h0, 16'h0);
        pulse_start();
        chk("jp.pc0", 32'(bus.pc), 32'h0);
        chk("jp.busy", 32'(bus.busy), 32'h1);
        chk("jp.done", 32'(bus.done), 32'h0);
        step("jp1", 16'h0010, 16'd0, 14'h0, 1'b0);
        step("jp2", 16'h0010, 16'd0, 14'h0, 1'b0);
        chk("jp.done2", 32'(bus.done), 32'h1);

        // ---- loop count 3 ----
        clr_mem();
        imem[0] = ins(LOOP, 14'h0, 16'd2, 16'd3);
        imem[1] = ins(EXEC, C_RF1, 16'h0, 16'h0);
        imem[2] = ins(EXEC, C_RF2, 16'h0, 16'h0);
        imem[3] = ins(HALT, 14'h0, 16'h0, 16'h0);
        pulse_start();
        chk("l3.pc0", 32'(bus.pc), 32'h0);
        rf1_n = 0; rf2_n = 0; lwe_n = 0;
        step("l3.1", 16'd1, 16'd3, 14'h0,  1'b1);
        step("l3.2", 16'd2, 16'd3, C_RF1, 1'b0);
        step("l3.3", 16'd1, 16'd2, C_RF2, 1'b0);
        step("l3.4", 16'd2, 16'd2, C_RF1, 1'b0);
        step("l3.5", 16'd1, 16'd1, C_RF2, 1'b0);
        step("l3.6", 16'd2, 16'd1, C_RF1, 1'b0);
        step("l3.7", 16'd3, 16'd0, C_RF2, 1'b0);
        step("l3.8", 16'd3, 16'd0, 14'h0,  1'b0);
        chk("l3.done", 32'(bus.done), 32'h1);
        chk("l3.rf1_n", 32'(rf1_n), 32'd3);
        chk("l3.rf2_n", 32'(rf2_n), 32'd3);
        chk("l3.lwe_n", 32'(lwe_n), 32'd1);

        // ---- loop count 0 ----
        imem[0] = ins(LOOP, 14'h0, 16'd2, 16'd0);
        pulse_start();
        rf1_n = 0; rf2_n = 0; lwe_n = 0;
        step("l0.1", 16'd3, 16'd0, 14'h0, 1'b1);
        step("l0.2", 16'd3, 16'd0, 14'h0, 1'b0);
        chk("l0.done", 32'(bus.done), 32'h1);
        chk("l0.body", 32'(rf1_n + rf2_n), 32'd0);
        chk("l0.lwe_n", 32'(lwe_n), 32'd1);

        // ---- nested loop, outer count 2 ----
        clr_mem();
        imem[0] = ins(LOOP, 14'h0, 16'd3, 16'd2);
        imem[1] = ins(EXEC, C_DM2, 16'h0, 16'h0);
        imem[2] = ins(LOOP, 14'h0, 16'd5, 16'd4);      // nested: ignored
        imem[3] = ins(EXEC, C_DAG1, 16'h0, 16'h0);
        imem[4] = ins(HALT, 14'h0, 16'h0, 16'h0);
        pulse_start();
        step("ns1", 16'd1, 16'd2, 14'h0,  1'b1);
        chk("ns.err0", 32'(bus.err), 32'h0);
        step("ns2", 16'd2, 16'd2, C_DM2,  1'b0);
        step("ns3", 16'd3, 16'd2, 14'h0,  1'b0);
        chk("ns.err1", 32'(bus.err), 32'h1);
        step("ns4", 16'd1, 16'd1, C_DAG1, 1'b0);
        step("ns5", 16'd2, 16'd1, C_DM2,  1'b0);
        step("ns6", 16'd3, 16'd1, 14'h0,  1'b0);
        step("ns7", 16'd4, 16'd0, C_DAG1, 1'b0);
        step("ns8", 16'd4, 16'd0, 14'h0,  1'b0);
        chk("ns.done", 32'(bus.done), 32'h1);
        chk("ns.err_sticky", 32'(bus.err), 32'h1);

        // ---- restart from HALT ----
        pulse_start();
        chk("rs.pc", 32'(bus.pc), 32'h0);
        chk("rs.err", 32'(bus.err), 32'h0);
        chk("rs.busy", 32'(bus.busy), 32'h1);
        chk("rs.done", 32'(bus.done), 32'h0);
        chk("rs.cnt", 32'(bus.loop_cnt), 32'h0);

        // ---- reset mid-loop ----
        step("rm1", 16'd1, 16'd2, 14'h0, 1'b1);
        step("rm2", 16'd2, 16'd2, C_DM2, 1'b0);
        step("rm3", 16'd3, 16'd2, 14'h0, 1'b0);
        chk("rm.err_set", 32'(bus.err), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm.pc", 32'(bus.pc), 32'h0);
        chk("rm.cnt", 32'(bus.loop_cnt), 32'h0);
        chk("rm.busy", 32'(bus.busy), 32'h0);
        chk("rm.done", 32'(bus.done), 32'h0);
        chk("rm.err", 32'(bus.err), 32'h0);
        chk("rm.strb", 32'(strb), 32'h0);
        tick();
        chk("rm.idle_pc", 32'(bus.pc), 32'h0);
        pulse_start();
        chk("rm.re_pc", 32'(bus.pc), 32'h0);
        chk("rm.re_busy", 32'(bus.busy), 32'h1);
        // loop state was really cleared: LOOP arms afresh instead of nesting
        step("rm4", 16'd1, 16'd2, 14'h0, 1'b1);
        chk("rm.re_err", 32'(bus.err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
